// File: rtl/scale_divider.sv
// rtl/scale_divider.sv - lock-step dual restoring divider mapping scaled products to pixel coordinates
// Both channels share one FSM and counter; outputs are saturated to XW/YW bits and held until the next result.
module scale_divider #(
   parameter int PW = 22,
   parameter int DW = 11,
   parameter int XW = 11,
   parameter int YW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [PW-1:0] x_prod,
   input  logic [PW-1:0] y_prod,
   input  logic [DW-1:0] x_div,
   input  logic [DW-1:0] y_div,
   output logic          busy,
   output logic          done,
   output logic [XW-1:0] x_q,
   output logic [YW-1:0] y_q,
   output logic          sat,
   output logic          div0
);

   localparam int CW = (PW > 1) ? $clog2(PW) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          load;
   logic          step;
   logic          finish;

   logic [CW-1:0] count;

   // Dividend registers double as quotient registers: each step shifts one
   // dividend bit out of the top and one quotient bit in at the bottom.
   logic [PW-1:0] x_dvd;
   logic [PW-1:0] y_dvd;
   logic [DW-1:0] x_dsr;
   logic [DW-1:0] y_dsr;
   logic [DW:0]   x_rem;
   logic [DW:0]   y_rem;

   logic [DW:0]   x_shift;
   logic [DW:0]   y_shift;
   logic [DW+1:0] x_trial;
   logic [DW+1:0] y_trial;
   logic          x_bit;
   logic          y_bit;
   logic [DW:0]   x_rem_nxt;
   logic [DW:0]   y_rem_nxt;

   logic          x_zero;
   logic          y_zero;
   logic          x_ovf;
   logic          y_ovf;
   logic [XW-1:0] x_q_nxt;
   logic [YW-1:0] y_q_nxt;

   always_comb begin
      x_shift   = {x_rem[DW-1:0], x_dvd[PW-1]};
      y_shift   = {y_rem[DW-1:0], y_dvd[PW-1]};
      x_trial   = {1'b0, x_shift} - {2'b00, x_dsr};
      y_trial   = {1'b0, y_shift} - {2'b00, y_dsr};
      x_bit     = ~x_trial[DW+1];
      y_bit     = ~y_trial[DW+1];
      x_rem_nxt = x_bit ? x_trial[DW:0] : x_shift;
      y_rem_nxt = y_bit ? y_trial[DW:0] : y_shift;
   end

   always_comb begin
      x_zero  = (x_dsr == '0);
      y_zero  = (y_dsr == '0);
      x_ovf   = |x_dvd[PW-1:XW];
      y_ovf   = |y_dvd[PW-1:YW];
      x_q_nxt = (x_zero || x_ovf) ? '1 : x_dvd[XW-1:0];
      y_q_nxt = (y_zero || y_ovf) ? '1 : y_dvd[YW-1:0];
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         x_dvd <= '0;
         y_dvd <= '0;
         x_dsr <= '0;
         y_dsr <= '0;
         x_rem <= '0;
         y_rem <= '0;
      end else if (load) begin
         count <= CW'(PW - 1);
         x_dvd <= x_prod;
         y_dvd <= y_prod;
         x_dsr <= x_div;
         y_dsr <= y_div;
         x_rem <= '0;
         y_rem <= '0;
      end else if (step) begin
         count <= count - 1'b1;
         x_dvd <= {x_dvd[PW-2:0], x_bit};
         y_dvd <= {y_dvd[PW-2:0], y_bit};
         x_rem <= x_rem_nxt;
         y_rem <= y_rem_nxt;
      end
   end

   // busy is registered so it spans the cycle after acceptance through the done cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
         sat  <= 1'b0;
         div0 <= 1'b0;
      end else begin
         busy <= (state != IDLE);
         done <= finish;
         if (finish) begin
            x_q  <= x_q_nxt;
            y_q  <= y_q_nxt;
            sat  <= (x_ovf && !x_zero) || (y_ovf && !y_zero);
            div0 <= x_zero || y_zero;
         end
      end
   end

endmodule

// File: tb/tb_scale_divider.sv
// tb/tb_scale_divider.sv - table-driven self-checking bench for scale_divider
// Vector table covers nominal, truncation, saturation and divide-by-zero; hand sequences cover busy and reset.
module tb_scale_divider;

   localparam int PW = 22;
   localparam int DW = 11;
   localparam int XW = 11;
   localparam int YW = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic [PW-1:0] x_prod;
   logic [PW-1:0] y_prod;
   logic [DW-1:0] x_div;
   logic [DW-1:0] y_div;
   logic          busy;
   logic          done;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          sat;
   logic          div0;

   int checks;
   int passes;

   scale_divider #(.PW(PW), .DW(DW), .XW(XW), .YW(YW)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .x_prod (x_prod),
      .y_prod (y_prod),
      .x_div  (x_div),
      .y_div  (y_div),
      .busy   (busy),
      .done   (done),
      .x_q    (x_q),
      .y_q    (y_q),
      .sat    (sat),
      .div0   (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    xp;
      int    xd;
      int    yp;
      int    yd;
      int    exp_xq;
      int    exp_yq;
      int    exp_sat;
      int    exp_div0;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives operands and a one-cycle start; returns at the negedge right after the accepting edge.
   task automatic launch(input int xp, input int xd, input int yp, input int yd);
      @(negedge clk);
      x_prod = PW'(xp);
      x_div  = DW'(xd);
      y_prod = PW'(yp);
      y_div  = DW'(yd);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (busy) bcnt++;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      int bcnt;
      launch(v.xp, v.xd, v.yp, v.yd);
      // Operands change after acceptance must not disturb the division.
      x_prod = PW'($urandom);
      y_prod = PW'($urandom);
      x_div  = DW'($urandom);
      y_div  = DW'($urandom);
      wait_done(lat, bcnt);
      chk({v.name, " latency"}, lat, 23);
      chk({v.name, " busy_cycles"}, bcnt, 23);
      chk({v.name, " x_q"}, int'(x_q), v.exp_xq);
      chk({v.name, " y_q"}, int'(y_q), v.exp_yq);
      chk({v.name, " sat"}, int'(sat), v.exp_sat);
      chk({v.name, " div0"}, int'(div0), v.exp_div0);
      @(negedge clk);
      chk({v.name, " done_pulse"}, int'(done), 0);
      chk({v.name, " busy_after"}, int'(busy), 0);
   endtask

   initial begin
      int lat;
      int bcnt;
      int ndone;
      int first_xq;
      int first_yq;

      checks = 0;
      passes = 0;

      vecs[0] = '{"nominal",    14880, 120,   36000, 120,  124,  300, 0, 0};
      vecs[1] = '{"truncation",  1000,   3,     479, 480,  333,    0, 0, 0};
      vecs[2] = '{"saturation", 4000000, 1,    2048,   2, 2047, 1023, 1, 0};
      vecs[3] = '{"div_zero",      600,   6,     500,   0,  100, 1023, 0, 1};
      vecs[4] = '{"exact_max",   10235,   5,    7161,   7, 2047, 1023, 0, 0};
      vecs[5] = '{"both_zero",       0,   0,       0,   0, 2047, 1023, 0, 1};
      vecs[6] = '{"full_scale", 4194303, 2047, 4194303, 2047, 2047, 1023, 1, 0};
      vecs[7] = '{"y_edge",       2047,   1,    1024,   1, 2047, 1023, 1, 0};

      reset  = 1'b1;
      start  = 1'b1;
      x_prod = PW'(14880);
      y_prod = PW'(36000);
      x_div  = DW'(120);
      y_div  = DW'(120);
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset x_q", int'(x_q), 0);
      chk("reset y_q", int'(y_q), 0);
      chk("reset sat", int'(sat), 0);
      chk("reset div0", int'(div0), 0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("reset_beats_start busy", int'(busy), 0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // A start raised mid-run must be dropped, not queued.
      launch(14880, 120, 36000, 120);
      repeat (4) @(negedge clk);
      x_prod = PW'(1000);
      x_div  = DW'(3);
      y_prod = PW'(479);
      y_div  = DW'(480);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      ndone    = 0;
      first_xq = -1;
      first_yq = -1;
      for (int c = 0; c < 60; c++) begin
         if (done) begin
            ndone++;
            if (first_xq < 0) begin
               first_xq = int'(x_q);
               first_yq = int'(y_q);
            end
         end
         @(negedge clk);
      end
      chk("ignored_start done_count", ndone, 1);
      chk("ignored_start x_q", first_xq, 124);
      chk("ignored_start y_q", first_yq, 300);

      // Reset ten clocks into a run abandons it.
      launch(600, 6, 500, 0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_reset busy", int'(busy), 0);
      chk("mid_reset done", int'(done), 0);
      chk("mid_reset x_q", int'(x_q), 0);
      chk("mid_reset y_q", int'(y_q), 0);
      chk("mid_reset sat", int'(sat), 0);
      chk("mid_reset div0", int'(div0), 0);
      ndone = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("mid_reset no_done", ndone, 0);

      launch(14880, 120, 36000, 120);
      wait_done(lat, bcnt);
      chk("post_reset latency", lat, 23);
      chk("post_reset x_q", int'(x_q), 124);
      chk("post_reset y_q", int'(y_q), 300);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
